// File: rtl/mips_pkg.sv
// Shared definitions for the instruction fetch unit.
//   fetch_state_e : fetch FSM state encoding
//   HALT_WORD_DEF : default instruction encoding that stops fetch
//   NOP_WORD      : value presented on the instruction bus when the PC is out of range
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_e;

    localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_WORD      = 32'h0000_0000;

endpackage

// File: rtl/instr_mem.sv
// Instruction memory: synchronous write, asynchronous (combinational) read.
// Contents are deliberately not reset so a program survives rst and clear.
//   clk     : write clock
//   i_we    : write enable
//   i_waddr : write word address
//   i_wdata : write data
//   i_raddr : read word address
//   o_rdata : read data (combinational)
module instr_mem #(
    parameter int DATA_W     = 32,
    parameter int IMEM_DEPTH = 256
) (
    input  logic                          clk,
    input  logic                          i_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] i_waddr,
    input  logic [DATA_W-1:0]             i_wdata,
    input  logic [$clog2(IMEM_DEPTH)-1:0] i_raddr,
    output logic [DATA_W-1:0]             o_rdata
);

    logic [DATA_W-1:0] mem_q [IMEM_DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: loads a program into instr_mem while idle, then
// fetches sequentially in free-run or single-step mode, with stall, jump,
// halt-word detection and out-of-range PC detection.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | program may be loaded; waits for i_start
// RUN   | fetches one word per cycle unless stalled
// STEP  | fetches one word per i_step pulse
// HALT  | halt word or out-of-range PC seen; waits for i_clear
//
// Ports:
//   clk, rst              : clock, asynchronous active-low reset
//   i_load_en/addr/data   : program load (honoured in IDLE only)
//   i_start, i_step_mode  : start fetch, mode sampled with start
//   i_step                : single-step pulse
//   i_stall               : hold PC
//   i_jump_en/addr        : redirect PC (word aligned)
//   i_clear               : leave HALT, PC back to RESET_PC
//   o_instruction         : word at current PC (0 when out of range)
//   o_pc, o_pc_plus4      : current PC and link value
//   o_valid               : o_instruction consumed this cycle
//   o_halted, o_error     : in HALT; halt caused by out-of-range PC
//   o_fetch_count         : valid fetches since start
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                IMEM_DEPTH = 256,
    parameter logic [DATA_W-1:0] RESET_PC   = '0,
    parameter logic [DATA_W-1:0] HALT_WORD  = DATA_W'(HALT_WORD_DEF)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_load_en,
    input  logic [$clog2(IMEM_DEPTH)-1:0] i_load_addr,
    input  logic [DATA_W-1:0]             i_load_data,
    input  logic                          i_start,
    input  logic                          i_step_mode,
    input  logic                          i_step,
    input  logic                          i_stall,
    input  logic                          i_jump_en,
    input  logic [DATA_W-1:0]             i_jump_addr,
    input  logic                          i_clear,
    output logic [DATA_W-1:0]             o_instruction,
    output logic [DATA_W-1:0]             o_pc,
    output logic [DATA_W-1:0]             o_pc_plus4,
    output logic                          o_valid,
    output logic                          o_halted,
    output logic                          o_error,
    output logic [31:0]                   o_fetch_count
);

    localparam int AW = $clog2(IMEM_DEPTH);
    // One extra bit so the byte limit cannot overflow the PC width.
    localparam logic [DATA_W:0] PC_LIMIT = (DATA_W+1)'(IMEM_DEPTH * 4);

    fetch_state_e      state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic              error_q, error_d;
    logic [31:0]       count_q, count_d;

    logic [DATA_W-1:0] mem_rdata;
    logic              mem_we;
    logic              in_range;
    logic              fetch_en;
    logic              halt_hit;
    logic              valid;
    logic [DATA_W-1:0] jump_target;

    // Writes are gated by rst as well so a load held across reset has no effect.
    assign mem_we = rst && (state_q == ST_IDLE) && i_load_en;

    instr_mem #(
        .DATA_W    (DATA_W),
        .IMEM_DEPTH(IMEM_DEPTH)
    ) u_instr_mem (
        .clk    (clk),
        .i_we   (mem_we),
        .i_waddr(i_load_addr),
        .i_wdata(i_load_data),
        .i_raddr(pc_q[AW+1:2]),
        .o_rdata(mem_rdata)
    );

    assign in_range      = ({1'b0, pc_q} < PC_LIMIT);
    assign o_instruction = in_range ? mem_rdata : DATA_W'(NOP_WORD);
    assign fetch_en      = (state_q == ST_RUN) || ((state_q == ST_STEP) && i_step);
    assign halt_hit      = in_range && (o_instruction == HALT_WORD);
    assign valid         = fetch_en && !i_stall && in_range && !halt_hit;
    assign jump_target   = i_jump_addr & ~DATA_W'(3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            error_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            error_q <= error_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        error_d = error_q;
        count_d = count_q;

        if (valid) begin
            count_d = count_q + 32'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = i_step_mode ? ST_STEP : ST_RUN;
                    count_d = '0;
                end
            end
            ST_RUN, ST_STEP: begin
                // Jump outranks everything, including halt and range detection.
                if (i_jump_en) begin
                    pc_d = jump_target;
                end else if (!in_range) begin
                    state_d = ST_HALT;
                    error_d = 1'b1;
                end else if (i_stall) begin
                    pc_d = pc_q;
                end else if (halt_hit && fetch_en) begin
                    state_d = ST_HALT;
                end else if (fetch_en) begin
                    pc_d = pc_q + DATA_W'(4);
                end
            end
            ST_HALT: begin
                if (i_clear) begin
                    state_d = ST_IDLE;
                    pc_d    = RESET_PC;
                    error_d = 1'b0;
                    count_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_pc          = pc_q;
    assign o_pc_plus4    = pc_q + DATA_W'(4);
    assign o_valid       = valid;
    assign o_halted      = (state_q == ST_HALT);
    assign o_error       = error_q;
    assign o_fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_t;

    logic        clk = 1'b0;
    logic        rst_a = 1'b0;
    logic        rst_b = 1'b0;
    logic        load_en = 1'b0;
    logic [7:0]  load_addr = '0;
    logic [31:0] load_data = '0;
    logic        start = 1'b0;
    logic        step_mode = 1'b0;
    logic        step = 1'b0;
    logic        stall = 1'b0;
    logic        jump_en = 1'b0;
    logic [31:0] jump_addr = '0;
    logic        clear = 1'b0;

    logic [31:0] a_instr, a_pc, a_pc4, a_count;
    logic        a_valid, a_halted, a_error;
    logic [31:0] b_instr, b_pc, b_pc4, b_count;
    logic        b_valid, b_halted, b_error;

    int     n_cmp = 0;
    int     n_err = 0;
    fetch_t exp_q[$];

    logic [31:0] prog_a [4] = '{32'h3C01_0001, 32'h3C03_0002, 32'h0023_3821, 32'hFFFF_FFFF};
    logic [31:0] prog_b [4] = '{32'h2401_0005, 32'h2402_0006, 32'h0022_1820, 32'hAC03_0010};

    always #5 clk = ~clk;

    instr_fetch_unit u_dut_a (
        .clk(clk), .rst(rst_a),
        .i_load_en(load_en), .i_load_addr(load_addr), .i_load_data(load_data),
        .i_start(start), .i_step_mode(step_mode), .i_step(step), .i_stall(stall),
        .i_jump_en(jump_en), .i_jump_addr(jump_addr), .i_clear(clear),
        .o_instruction(a_instr), .o_pc(a_pc), .o_pc_plus4(a_pc4), .o_valid(a_valid),
        .o_halted(a_halted), .o_error(a_error), .o_fetch_count(a_count)
    );

    instr_fetch_unit #(.IMEM_DEPTH(4)) u_dut_b (
        .clk(clk), .rst(rst_b),
        .i_load_en(load_en), .i_load_addr(load_addr[1:0]), .i_load_data(load_data),
        .i_start(start), .i_step_mode(step_mode), .i_step(step), .i_stall(stall),
        .i_jump_en(jump_en), .i_jump_addr(jump_addr), .i_clear(clear),
        .o_instruction(b_instr), .o_pc(b_pc), .o_pc_plus4(b_pc4), .o_valid(b_valid),
        .o_halted(b_halted), .o_error(b_error), .o_fetch_count(b_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr);
        fetch_t e;
        e.pc    = pc;
        e.instr = instr;
        exp_q.push_back(e);
    endtask

    task automatic sb_check(input string nm, input logic [31:0] pc, input logic [31:0] instr);
        fetch_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: unexpected fetch pc=%h instr=%h, none expected", nm, pc, instr);
        end else begin
            e = exp_q.pop_front();
            chk({nm, "_pc"}, pc, e.pc);
            chk({nm, "_instr"}, instr, e.instr);
        end
    endtask

    // Scoreboard monitor: every consumed fetch must match the next expected entry.
    always @(negedge clk) begin
        if (rst_a && a_valid) sb_check("fetch_a", a_pc, a_instr);
        if (rst_b && b_valid) sb_check("fetch_b", b_pc, b_instr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_halt(input bit use_b, input int max_cyc);
        bit done = 1'b0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            @(negedge clk);
            if (use_b ? b_halted : a_halted) done = 1'b1;
        end
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL wait_halt: halted=0 after %0d cycles, expected 1", max_cyc);
        end
    endtask

    task automatic load_prog(input bit use_b);
        for (int i = 0; i < 4; i++) begin
            load_en   = 1'b1;
            load_addr = 8'(i);
            load_data = use_b ? prog_b[i] : prog_a[i];
            tick();
        end
        load_en = 1'b0;
    endtask

    task automatic clear_a();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        @(negedge clk);
        chk("clear_pc", a_pc, 32'h0);
        chk1("clear_halted", a_halted, 1'b0);
        chk1("clear_error", a_error, 1'b0);
        chk("clear_count", a_count, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_a = 1'b1;
        @(negedge clk);
        chk("rst_pc", a_pc, 32'h0);
        chk("rst_pc4", a_pc4, 32'h4);
        chk1("rst_valid", a_valid, 1'b0);
        chk1("rst_halted", a_halted, 1'b0);
        chk1("rst_error", a_error, 1'b0);
        chk("rst_count", a_count, 32'd0);

        load_prog(1'b0);

        // Free run to the halt word.
        start = 1'b1;
        push(32'h0, prog_a[0]);
        push(32'h4, prog_a[1]);
        push(32'h8, prog_a[2]);
        tick();
        start = 1'b0;
        wait_halt(1'b0, 20);
        chk("run_halt_pc", a_pc, 32'hC);
        chk("run_count", a_count, 32'd3);
        chk1("run_error", a_error, 1'b0);
        clear_a();

        // Stall at PC 4 for two cycles, then jump to 0xE during a stall.
        start = 1'b1;
        push(32'h0, prog_a[0]);
        tick();
        start = 1'b0;
        tick();
        stall = 1'b1;
        @(negedge clk);
        chk("stall1_pc", a_pc, 32'h4);
        chk1("stall1_valid", a_valid, 1'b0);
        chk("stall1_count", a_count, 32'd1);
        tick();
        @(negedge clk);
        chk("stall2_pc", a_pc, 32'h4);
        chk1("stall2_valid", a_valid, 1'b0);
        tick();
        stall = 1'b0;
        push(32'h4, prog_a[1]);
        tick();
        stall = 1'b1;
        jump_en = 1'b1;
        jump_addr = 32'h0000_000E;
        @(negedge clk);
        chk("resume_pc", a_pc, 32'h8);
        chk1("jump_stall_valid", a_valid, 1'b0);
        tick();
        stall = 1'b0;
        jump_en = 1'b0;
        @(negedge clk);
        chk("jump_pc", a_pc, 32'hC);
        wait_halt(1'b0, 10);
        chk("stall_count", a_count, 32'd2);
        clear_a();

        // Single-step mode.
        step_mode = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        step_mode = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        chk("step_idle_pc", a_pc, 32'h0);
        chk1("step_idle_valid", a_valid, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            push(32'(4 * k), prog_a[k]);
            tick();
            step = 1'b0;
            repeat (4) tick();
            @(negedge clk);
            chk("step_pc", a_pc, 32'(4 * (k + 1)));
        end
        chk("step_count", a_count, 32'd3);
        chk1("step_halted", a_halted, 1'b0);
        // Step onto the halt word together with a jump: jump wins.
        step = 1'b1;
        jump_en = 1'b1;
        jump_addr = 32'h0;
        tick();
        step = 1'b0;
        jump_en = 1'b0;
        @(negedge clk);
        chk("jump_over_halt_pc", a_pc, 32'h0);
        tick();
        chk1("jump_over_halt_halted", a_halted, 1'b0);
        // Jump without a step to the top of the address space.
        jump_en = 1'b1;
        jump_addr = 32'hFFFF_FFFF;
        tick();
        jump_en = 1'b0;
        @(negedge clk);
        chk("oor_pc", a_pc, 32'hFFFF_FFFC);
        chk("oor_pc4_wrap", a_pc4, 32'h0);
        chk("oor_instr", a_instr, 32'h0);
        chk1("oor_valid", a_valid, 1'b0);
        wait_halt(1'b0, 5);
        chk1("oor_error", a_error, 1'b1);
        chk("oor_count", a_count, 32'd3);
        clear_a();

        // Reset mid-run at PC 8 with a load attempted while running.
        start = 1'b1;
        push(32'h0, prog_a[0]);
        push(32'h4, prog_a[1]);
        tick();
        start = 1'b0;
        load_en = 1'b1;
        load_addr = 8'd1;
        load_data = 32'hDEAD_BEEF;
        tick();
        tick();
        chk("pre_rst_pc", a_pc, 32'h8);
        #1;
        rst_a = 1'b0;
        load_en = 1'b0;
        #1;
        chk("mid_rst_pc", a_pc, 32'h0);
        chk1("mid_rst_valid", a_valid, 1'b0);
        chk1("mid_rst_halted", a_halted, 1'b0);
        chk("mid_rst_count", a_count, 32'd0);
        @(posedge clk);
        #1 rst_a = 1'b1;
        @(negedge clk);
        chk("mem_word0", a_instr, prog_a[0]);
        step_mode = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        step_mode = 1'b0;
        jump_en = 1'b1;
        jump_addr = 32'h4;
        tick();
        jump_en = 1'b0;
        @(negedge clk);
        chk("mem_word1_pc", a_pc, 32'h4);
        chk("mem_word1", a_instr, prog_a[1]);

        // Small memory, no halt word: run off the end.
        rst_a = 1'b0;
        @(posedge clk);
        #1 rst_b = 1'b1;
        load_prog(1'b1);
        start = 1'b1;
        for (int k = 0; k < 4; k++) push(32'(4 * k), prog_b[k]);
        tick();
        start = 1'b0;
        wait_halt(1'b1, 20);
        chk("b_halt_pc", b_pc, 32'h10);
        chk1("b_error", b_error, 1'b1);
        chk("b_count", b_count, 32'd4);
        chk("b_oor_instr", b_instr, 32'h0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        @(negedge clk);
        chk("b_clear_pc", b_pc, 32'h0);
        chk1("b_clear_error", b_error, 1'b0);
        chk1("b_clear_halted", b_halted, 1'b0);

        chk("sb_pending", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction and PC width in bits.
REQ-002 SHALL have parameter IMEM_DEPTH, default 256, instruction memory depth in words; AW = clog2(IMEM_DEPTH).
REQ-003 SHALL have parameter RESET_PC, default 0, byte address loaded into PC on reset and clear.
REQ-004 SHALL have parameter HALT_WORD, default 32'hFFFF_FFFF, instruction encoding that stops fetch.
REQ-005 clk  in  1  sole clock; all state changes on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 i_load_en  in  1  write one instruction word into memory (IDLE only).
REQ-008 i_load_addr  in  AW  word address of load.
REQ-009 i_load_data  in  DATA_W  instruction word to load.
REQ-010 i_start  in  1  leave IDLE and begin fetching.
REQ-011 i_step_mode  in  1  sampled with i_start; 1 = single-step, 0 = free run.
REQ-012 i_step  in  1  one-cycle pulse; advances one fetch in STEP.
REQ-013 i_stall  in  1  hazard stall; hold PC.
REQ-014 i_jump_en  in  1  redirect PC to i_jump_addr.
REQ-015 i_jump_addr  in  DATA_W  byte target address.
REQ-016 i_clear  in  1  leave HALT, PC to RESET_PC, memory preserved.
REQ-017 o_instruction  out  DATA_W  word at current PC (combinational read).
REQ-018 o_pc  out  DATA_W  current byte PC.
REQ-019 o_pc_plus4  out  DATA_W  o_pc + 4 (link value).
REQ-020 o_valid  out  1  o_instruction is a fetch consumed this cycle.
REQ-021 o_halted  out  1  state is HALT.
REQ-022 o_error  out  1  sticky; halt caused by out-of-range PC.
REQ-023 o_fetch_count  out  32  number of valid fetches since start.

Function
REQ-024 FSM states SHALL be IDLE, RUN, STEP, HALT.
REQ-025 IDLE: i_load_en writes mem[i_load_addr] next edge; loads in any other state SHALL be ignored.
REQ-026 IDLE->RUN on i_start with i_step_mode=0; IDLE->STEP on i_start with i_step_mode=1; i_start outside IDLE ignored.
REQ-027 o_valid SHALL be 1 when (RUN, or STEP with i_step=1) and i_stall=0 and o_instruction != HALT_WORD and PC in range.
REQ-028 PC update priority per edge, in RUN/STEP: i_jump_en (target with bits[1:0] forced to 0) > i_stall (hold) > advance (PC+4, RUN always, STEP only on i_step).
REQ-029 i_jump_en SHALL redirect even while i_stall=1 or, in STEP, without i_step.
REQ-030 Fetched word == HALT_WORD with i_stall=0 SHALL move to HALT next edge; PC holds at halt word address.
REQ-031 PC >= IMEM_DEPTH*4 in RUN/STEP SHALL move to HALT next edge and set o_error; o_instruction SHALL read 0 while out of range.
REQ-032 Jump and HALT detection in same cycle: jump wins, no halt.
REQ-033 HALT->IDLE on i_clear: PC=RESET_PC, o_error=0, o_fetch_count=0; other inputs ignored in HALT.
REQ-034 o_fetch_count SHALL increment by 1 on every edge with o_valid=1, wrapping at 2^32.
REQ-035 o_pc_plus4 SHALL wrap modulo 2^DATA_W.

Reset
REQ-036 rst low SHALL asynchronously force state IDLE, PC=RESET_PC, o_error=0, o_fetch_count=0, o_valid=0, o_halted=0.
REQ-037 Memory contents SHALL NOT be cleared by reset; reset mid-RUN aborts fetch with no further memory effect.

Structure
REQ-038 State encoding, HALT_WORD and NOP word constants SHALL live in shared package mips_pkg.
REQ-039 Memory SHALL be sub-module instr_mem (sync write, async read, parameters DATA_W, IMEM_DEPTH).
REQ-040 PC adder and jump mux SHALL be inline; no other sub-modules.

Verification
REQ-041 Load words 0..3 = 0x3C010001,0x3C030002,0x00233821,0xFFFFFFFF, start free run -> o_pc 0,4,8,12, o_valid 3 cycles, o_halted=1, o_fetch_count=3.
REQ-042 RUN at PC=4, i_stall=1 for 2 cycles -> o_pc stays 4, o_valid=0, count unchanged; resumes at 8.
REQ-043 i_jump_en with i_jump_addr=0x0000000E during stall -> next o_pc=0x0C.
REQ-044 STEP mode, three i_step pulses spaced 5 cycles -> o_pc 0->4->8->12, count=3, PC static between pulses.
REQ-045 IMEM_DEPTH=4, no halt word, free run -> PC reaches 16, o_halted=1, o_error=1; i_clear -> IDLE, PC=0, o_error=0.
REQ-046 rst low mid-RUN at PC=8, load during RUN attempted -> state IDLE, PC=0, prior memory contents intact, ignored load absent.
